fill_dma_arbiter: RTL and testbench

- Shares the memory-map CPU-side port (address, write data, memop, write enable) between the CPU and a word-fill engine.
- The fill engine writes a constant 32-bit word into a contiguous range. Its main use is clearing or blanking lines in VGA char RAM (0x00300000) and color RAM (0x00400000) without CPU store loops.
- Sits between the CPU and memory_map. The CPU always has priority; the engine only uses idle bus cycles.
- Configured through a register window at FILL_BASE.

---
 rtl/fill_dma_arbiter_if.sv | 33 +++
 rtl/fill_dma_arbiter.sv | 111 +++++++++++
 tb/tb_fill_dma_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fill_dma_arbiter_if.sv
// CPU-side memory-map bus plus fill-engine status, shared between the CPU
// and the word-fill engine arbiter.
interface fill_dma_arbiter_if;
    // Request semantics: the CPU owns the bus in any cycle where cpu_we or
    // cpu_re is high. There is no ready/stall back to the CPU. The engine
    // only issues a store (mem_we=1) in cycles where the CPU makes no request.
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wrdata;
    logic [2:0]  cpu_memop;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wrdata;
    logic [2:0]  mem_memop;
    logic        mem_we;
    logic        fill_sel;
    logic [31:0] fill_rddata;
    logic        fill_busy;
    logic        fill_done;
    logic [1:0]  dbg_state;

    modport master (
        output cpu_addr, cpu_wrdata, cpu_memop, cpu_we, cpu_re,
        input  mem_addr, mem_wrdata, mem_memop, mem_we,
        input  fill_sel, fill_rddata, fill_busy, fill_done, dbg_state
    );

    modport slave (
        input  cpu_addr, cpu_wrdata, cpu_memop, cpu_we, cpu_re,
        output mem_addr, mem_wrdata, mem_memop, mem_we,
        output fill_sel, fill_rddata, fill_busy, fill_done, dbg_state
    );
endinterface

// File: rtl/fill_dma_arbiter.sv
// Shares the memory-map CPU port between the CPU and a constant-word fill
// engine; the CPU always wins, the engine stores only in idle bus cycles.
module fill_dma_arbiter #(
    parameter logic [31:0] FILL_BASE  = 32'h00830000,
    parameter logic [2:0]  WORD_MEMOP = 3'b010
) (
    input logic               clk,
    input logic               rst,
    fill_dma_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_next;
    logic [31:0] dst, count, data, cur_addr, remaining;
    logic        done_sticky;
    logic [15:0] off;
    logic        cpu_req, granted, busy, cfg_wr, start_wr, abort_wr;

    assign off          = bus.cpu_addr[15:0];
    assign bus.fill_sel = (bus.cpu_addr & 32'hFFFF0000) == FILL_BASE;
    assign cpu_req      = bus.cpu_we | bus.cpu_re;
    assign busy         = (state == RUN);
    assign granted      = busy && !cpu_req;
    assign cfg_wr       = bus.cpu_we && bus.fill_sel;
    assign start_wr     = cfg_wr && (off == 16'h000C) && bus.cpu_wrdata[0];
    assign abort_wr     = cfg_wr && (off == 16'h000C) && bus.cpu_wrdata[1];

    assign bus.fill_busy = busy;
    assign bus.fill_done = (state == DONE);
    assign bus.dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_wr) state_next = (count == 32'd0) ? DONE : RUN;
            // abort_wr implies cpu_we, so it never coincides with a granted store
            RUN: begin
                if (abort_wr)                               state_next = DONE;
                else if (granted && remaining == 32'd1)     state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst         <= '0;
            count       <= '0;
            data        <= '0;
            cur_addr    <= '0;
            remaining   <= '0;
            done_sticky <= 1'b0;
        end else begin
            if (cfg_wr && !busy) begin
                case (off)
                    16'h0000: dst   <= {bus.cpu_wrdata[31:2], 2'b00};
                    16'h0004: count <= bus.cpu_wrdata;
                    16'h0008: data  <= bus.cpu_wrdata;
                    default:  ;
                endcase
            end
            case (state)
                IDLE: if (start_wr) begin
                    cur_addr    <= dst;
                    remaining   <= count;
                    done_sticky <= 1'b0;
                end
                RUN: if (granted) begin
                    cur_addr  <= cur_addr + 32'd4;
                    remaining <= remaining - 32'd1;
                end
                DONE:    done_sticky <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.fill_rddata = '0;
        if (bus.fill_sel) begin
            case (off)
                16'h0000: bus.fill_rddata = dst;
                16'h0004: bus.fill_rddata = count;
                16'h0008: bus.fill_rddata = data;
                16'h000C: bus.fill_rddata = {30'b0, done_sticky, busy};
                default:  bus.fill_rddata = '0;
            endcase
        end
    end

    // Config-window stores are swallowed here so they never reach memory_map.
    always_comb begin
        if (granted) begin
            bus.mem_addr   = cur_addr;
            bus.mem_wrdata = data;
            bus.mem_memop  = WORD_MEMOP;
            bus.mem_we     = 1'b1;
        end else begin
            bus.mem_addr   = bus.cpu_addr;
            bus.mem_wrdata = bus.cpu_wrdata;
            bus.mem_memop  = bus.cpu_memop;
            bus.mem_we     = bus.cpu_we && !bus.fill_sel;
        end
    end
endmodule

// File: tb/tb_fill_dma_arbiter.sv
// Directed bench for fill_dma_arbiter: vector table for the main fills,
// hand-written sequences for abort and reset in mid-fill.
module tb_fill_dma_arbiter;
    localparam logic [31:0] B = 32'h00830000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  m;
        logic        we;
        logic        re;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_memop;
        logic        e_we;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_rd;
    } vec_t;

    logic clk;
    logic rst;
    fill_dma_arbiter_if bus();

    fill_dma_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    vec_t vq[$];
    logic [31:0] exp_q[$];
    int stores;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_cpu(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                                    input logic we, input logic re, input logic ewe,
                                    input logic eb, input logic edn, input logic [31:0] erd);
        vec_t v;
        v.a = a; v.d = d; v.m = m; v.we = we; v.re = re;
        v.e_addr = a; v.e_data = d; v.e_memop = m; v.e_we = ewe;
        v.e_busy = eb; v.e_done = edn; v.e_rd = erd;
        vq.push_back(v);
    endfunction

    function automatic void add_eng(input logic [31:0] ea, input logic [31:0] ed);
        vec_t v;
        v.a = '0; v.d = '0; v.m = '0; v.we = 1'b0; v.re = 1'b0;
        v.e_addr = ea; v.e_data = ed; v.e_memop = 3'b010; v.e_we = 1'b1;
        v.e_busy = 1'b1; v.e_done = 1'b0; v.e_rd = '0;
        vq.push_back(v);
    endfunction

    // driver tasks
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                         input logic we, input logic re);
        @(negedge clk);
        bus.cpu_addr = a; bus.cpu_wrdata = d; bus.cpu_memop = m;
        bus.cpu_we = we; bus.cpu_re = re;
        #1;
    endtask

    task automatic cfg_wr(input logic [31:0] off, input logic [31:0] d);
        drive(B + off, d, 3'b010, 1'b1, 1'b0);
        chk($sformatf("cfg_wr %h mem_we", off), {31'b0, bus.mem_we}, 32'd0);
    endtask

    // idle CPU cycle; any engine store is scored against exp_q
    task automatic idle_cycle(input logic [31:0] e_data);
        drive('0, '0, '0, 1'b0, 1'b0);
        if (bus.mem_we) begin
            stores++;
            if (exp_q.size() == 0) begin
                chk("unexpected store addr", bus.mem_addr, 32'hXXXXXXXX);
            end else begin
                chk($sformatf("store%0d addr", stores), bus.mem_addr, exp_q.pop_front());
                chk($sformatf("store%0d data", stores), bus.mem_wrdata, e_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_addr = '0; bus.cpu_wrdata = '0; bus.cpu_memop = '0;
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;

        // reset state and passthrough
        add_cpu(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add_cpu(32'h00100010, 32'hDEADBEEF, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        // fill of 4 words with idle CPU
        add_cpu(B + 32'h0, 32'h00300000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add_cpu(B + 32'h4, 32'd4,        3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add_cpu(B + 32'h8, 32'h20,       3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add_cpu(B + 32'hC, 32'h1,        3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        add_eng(32'h00300000, 32'h20);
        add_eng(32'h00300004, 32'h20);
        add_eng(32'h00300008, 32'h20);
        add_eng(32'h0030000C, 32'h20);
        add_cpu(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        add_cpu(B + 32'hC,  32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2);
        add_cpu(B + 32'h0,  32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00300000);
        add_cpu(B + 32'h4,  32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        add_cpu(B + 32'h8,  32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
        add_cpu(B + 32'h10, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // same fill, CPU loads in RUN cycles 2-3
        add_cpu(B + 32'hC, 32'h1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2);
        add_eng(32'h00300000, 32'h20);
        add_cpu(32'h00100020, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        add_cpu(B + 32'hC,    32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1);
        add_eng(32'h00300004, 32'h20);
        add_eng(32'h00300008, 32'h20);
        add_eng(32'h0030000C, 32'h20);
        add_cpu(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        add_cpu(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        // COUNT = 0: straight to DONE, no stores
        add_cpu(B + 32'h4, 32'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4);
        add_cpu(B + 32'hC, 32'h1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2);
        add_cpu(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        add_cpu(B + 32'hC, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2);
        // address wrap; DST low bits masked
        add_cpu(B + 32'h0, 32'hFFFFFFFB, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00300000);
        add_cpu(B + 32'h4, 32'd3,        3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        add_cpu(B + 32'h0, 32'h0,        3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8);
        add_cpu(B + 32'hC, 32'h1,        3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2);
        add_eng(32'hFFFFFFF8, 32'h20);
        add_eng(32'hFFFFFFFC, 32'h20);
        add_eng(32'h00000000, 32'h20);
        add_cpu(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        repeat (3) @(negedge clk);
        #1;
        chk("in reset fill_busy", {31'b0, bus.fill_busy}, 32'd0);
        chk("in reset fill_done", {31'b0, bus.fill_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].a, vq[i].d, vq[i].m, vq[i].we, vq[i].re);
            chk($sformatf("v%0d mem_addr", i),   bus.mem_addr, vq[i].e_addr);
            chk($sformatf("v%0d mem_wrdata", i), bus.mem_wrdata, vq[i].e_data);
            chk($sformatf("v%0d mem_memop", i),  {29'b0, bus.mem_memop}, {29'b0, vq[i].e_memop});
            chk($sformatf("v%0d mem_we", i),     {31'b0, bus.mem_we}, {31'b0, vq[i].e_we});
            chk($sformatf("v%0d fill_busy", i),  {31'b0, bus.fill_busy}, {31'b0, vq[i].e_busy});
            chk($sformatf("v%0d fill_done", i),  {31'b0, bus.fill_done}, {31'b0, vq[i].e_done});
            chk($sformatf("v%0d fill_rddata", i), bus.fill_rddata, vq[i].e_rd);
        end

        // abort a 100-word fill after 10 stores; DATA write while busy is ignored
        cfg_wr(32'h0, 32'h00400000);
        cfg_wr(32'h4, 32'd100);
        cfg_wr(32'h8, 32'h7);
        cfg_wr(32'hC, 32'h1);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'h00400000 + 32'(4 * i));
        stores = 0;
        for (int k = 0; k < 20 && stores < 5; k++) idle_cycle(32'h7);
        chk("abort first 5 stores", stores, 5);
        cfg_wr(32'h8, 32'h1);
        for (int k = 0; k < 20 && stores < 10; k++) idle_cycle(32'h7);
        chk("abort 10 stores", stores, 10);
        cfg_wr(32'hC, 32'h2);
        chk("abort cycle busy", {31'b0, bus.fill_busy}, 32'd1);
        idle_cycle(32'h7);
        chk("abort done pulse", {31'b0, bus.fill_done}, 32'd1);
        chk("abort done busy", {31'b0, bus.fill_busy}, 32'd0);
        for (int k = 0; k < 5; k++) idle_cycle(32'h7);
        chk("abort total stores", stores, 10);
        chk("abort queue empty", exp_q.size(), 0);
        drive(B + 32'h8, '0, '0, 1'b0, 1'b1);
        chk("abort DATA kept", bus.fill_rddata, 32'h7);
        drive(B + 32'hC, '0, '0, 1'b0, 1'b1);
        chk("abort CTRL", bus.fill_rddata, 32'h2);

        // reset mid-fill: back to IDLE, passthrough, registers cleared
        cfg_wr(32'h4, 32'd50);
        cfg_wr(32'hC, 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive('0, '0, '0, 1'b0, 1'b0);
            chk($sformatf("rst-fill store%0d addr", k), bus.mem_addr, 32'h00400000 + 32'(4 * k));
        end
        @(negedge clk);
        bus.cpu_addr = 32'h00100040;
        rst = 1'b1;
        #1;
        chk("mid rst busy", {31'b0, bus.fill_busy}, 32'd0);
        chk("mid rst mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("mid rst mem_addr", bus.mem_addr, 32'h00100040);
        @(negedge clk);
        rst = 1'b0;
        drive(B + 32'h0, '0, '0, 1'b0, 1'b1);
        chk("post rst DST", bus.fill_rddata, 32'h0);
        drive(B + 32'hC, '0, '0, 1'b0, 1'b1);
        chk("post rst CTRL", bus.fill_rddata, 32'h0);
        idle_cycle(32'h0);
        chk("post rst no store", {31'b0, bus.mem_we}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
